uart_rx_ctrl: RTL

Sequencer for the UART `receiver` block. It drives the receiver's `enabled` input and monitors its busy/done/err outputs. Good bytes go into a small first-word-fall-through FIFO exposed as a valid/ready stream; framing errors, overflows and stuck frames are counted as status for the host side.

---
 rtl/uart_rx_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencer for the UART receiver block.
//   Drives the receiver's enable and watches its busy/done/err outputs.
//   Good bytes are queued in a first-word-fall-through FIFO and offered as
//   a valid/ready stream. Framing errors, dropped bytes and stuck frames are
//   reported as host status.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   en                  software receive enable
//   clear               pulse: zero overflow, err_count, timeout_count
//   flush               pulse: empty the FIFO
//   rx_enabled          -> receiver enable
//   rx_busy/done/err    <- receiver status (err qualified by done)
//   rx_data             <- receiver byte
//   m_data/m_valid      FIFO head stream, m_ready accepts it
//   fifo_count          FIFO occupancy
//   overflow            sticky: good byte dropped on full FIFO
//   err_count           framing errors, saturating
//   timeout_count       frame timeouts, saturating

package definitions_pkg;
  localparam int CLOCK_RATE = 50_000_000;
  localparam int BAUD_RATE  = 115_200;
endpackage

module uart_rx_ctrl #(
  parameter int DEPTH          = 8,
  parameter int FRAME_TIMEOUT  = 11 * (definitions_pkg::CLOCK_RATE / definitions_pkg::BAUD_RATE),
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     flush,
  output logic                     rx_enabled,
  input  logic                     rx_busy,
  input  logic                     rx_done,
  input  logic                     rx_err,
  input  logic [7:0]               rx_data,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               err_count,
  output logic [7:0]               timeout_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(FRAME_TIMEOUT) + 1;
  localparam int RW = $clog2(RECOVER_CYCLES) + 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ARMED     = 2'd1;
  localparam logic [1:0] RECEIVING = 2'd2;
  localparam logic [1:0] RECOVER   = 2'd3;

  logic [1:0]    state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [RW-1:0] rec_cnt, rec_cnt_n;
  logic          done_q;
  logic          done_ev;
  logic          push_req, err_inc, to_inc;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, do_push, do_pop;

  assign done_ev = rx_done & ~done_q;

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    rec_cnt_n = rec_cnt;
    push_req  = 1'b0;
    err_inc   = 1'b0;
    to_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_n = ARMED;
      end
      ARMED: begin
        // A done event here means busy was too short to be sampled.
        if (done_ev) begin
          push_req = ~rx_err;
          err_inc  = rx_err;
          state_n  = en ? ARMED : IDLE;
        end else if (!en) begin
          state_n = IDLE;
        end else if (rx_busy) begin
          state_n = RECEIVING;
          timer_n = '0;
        end
      end
      RECEIVING: begin
        timer_n = timer + 1'b1;
        if (done_ev) begin
          push_req = ~rx_err;
          err_inc  = rx_err;
          state_n  = en ? ARMED : IDLE;
        end else if (timer == TW'(FRAME_TIMEOUT - 1)) begin
          to_inc    = 1'b1;
          state_n   = RECOVER;
          rec_cnt_n = '0;
        end
      end
      default: begin
        rec_cnt_n = rec_cnt + 1'b1;
        if (rec_cnt == RW'(RECOVER_CYCLES - 1)) state_n = en ? ARMED : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      rec_cnt    <= '0;
      done_q     <= 1'b0;
      rx_enabled <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      rec_cnt    <= rec_cnt_n;
      done_q     <= rx_done;
      rx_enabled <= (state_n == ARMED) || (state_n == RECEIVING);
    end
  end

  // FIFO: a full FIFO still takes a push when the head is popped the same cycle.
  assign m_valid = (fifo_count != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign full    = (fifo_count == ($clog2(DEPTH)+1)'(DEPTH));
  assign pop     = m_valid & m_ready;
  assign do_pop  = pop & ~flush;
  assign do_push = push_req & (~full | pop) & ~flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      fifo_count <= fifo_count + 1'b1;
      else if (do_pop && !do_push) fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow      <= 1'b0;
      err_count     <= '0;
      timeout_count <= '0;
    end else if (clear) begin
      overflow      <= 1'b0;
      err_count     <= '0;
      timeout_count <= '0;
    end else begin
      if (push_req && full && !pop && !flush) overflow <= 1'b1;
      if (err_inc && err_count != '1)         err_count <= err_count + 1'b1;
      if (to_inc && timeout_count != '1)      timeout_count <= timeout_count + 1'b1;
    end
  end

endmodule
